// File: rtl/pdm_capture_pkg.sv
// Shared constants and channel encoding for the stereo PDM pair capture path.
package pdm_capture_pkg;

    localparam int DEF_WORD_W     = 16;
    localparam int DEF_SAMPLE_DLY = 2;
    localparam int DEF_TIMEOUT    = 32;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus edge-detect flop for one asynchronous level.
// Rise/fall pulse one cycle, two clk edges after the pin is first captured; no backpressure.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/pdm_pair_capture.sv
// Stereo PDM pair deserialiser: L on mic-clock rise, R on fall, WORD_W-bit words out.
// Word appears the cycle after the final R sample; while held unaccepted, new pairs drop and set overrun.
module pdm_pair_capture
    import pdm_capture_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int SAMPLE_DLY = DEF_SAMPLE_DLY,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mic_clk_in,
    input  logic              mic_data_in,
    output logic [WORD_W-1:0] word_l,
    output logic [WORD_W-1:0] word_r,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overrun,
    output logic              clk_lost
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int DLY_W = $clog2(SAMPLE_DLY + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SAMPLE_DLY - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    logic mc_lvl, mc_rise, mc_fall, mc_edge;

    edge_sync u_mic_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mic_clk_in),
        .level   (mc_lvl),
        .rise    (mc_rise),
        .fall    (mc_fall)
    );

    assign mc_edge = mc_rise | mc_fall;

    logic [1:0]        data_sync_q, data_sync_d;
    logic [WORD_W-1:0] sr_l_q, sr_l_d, sr_r_q, sr_r_d;
    logic [WORD_W-1:0] word_l_q, word_l_d, word_r_q, word_r_d;
    logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    ch_e               pend_ch_q, pend_ch_d;
    logic              pend_q, pend_d;
    logic              locked_q, locked_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              lost_q, lost_d;
    logic              take, complete, edge_use;

    always_comb begin
        data_sync_d = {data_sync_q[0], mic_data_in};
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        word_l_d    = word_l_q;
        word_r_d    = word_r_q;
        pair_cnt_d  = pair_cnt_q;
        dly_cnt_d   = dly_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        pend_ch_d   = pend_ch_q;
        pend_d      = pend_q;
        locked_d    = locked_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        lost_d      = lost_q;
        take        = 1'b0;
        complete    = 1'b0;
        edge_use    = 1'b0;

        if (!enable) begin
            sr_l_d     = '0;
            sr_r_d     = '0;
            pair_cnt_d = '0;
            dly_cnt_d  = '0;
            wd_cnt_d   = '0;
            pend_ch_d  = CH_L;
            pend_d     = 1'b0;
            locked_d   = 1'b0;
            valid_d    = 1'b0;
            ovr_d      = 1'b0;
            lost_d     = 1'b0;
        end else begin
            if (valid_q && word_ready) begin
                valid_d = 1'b0;
            end

            if (mc_edge) begin
                wd_cnt_d = '0;
                lost_d   = 1'b0;
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end

            // A fresh edge forces out a sample that is still waiting on its delay.
            take = pend_q && (mc_edge || (dly_cnt_q == DLY_LAST));
            if (take) begin
                pend_d = 1'b0;
                if (pend_ch_q == CH_L) begin
                    sr_l_d = {sr_l_q[WORD_W-2:0], data_sync_q[1]};
                end else begin
                    sr_r_d = {sr_r_q[WORD_W-2:0], data_sync_q[1]};
                    if (pair_cnt_q == CNT_LAST) begin
                        complete   = 1'b1;
                        pair_cnt_d = '0;
                    end else begin
                        pair_cnt_d = pair_cnt_q + 1'b1;
                    end
                end
            end else if (pend_q) begin
                dly_cnt_d = dly_cnt_q + 1'b1;
            end

            // Until a rise is seen, falls are discarded so every pair starts with L.
            edge_use = mc_rise || (mc_fall && locked_q);
            if (mc_rise) begin
                locked_d = 1'b1;
            end
            if (edge_use) begin
                pend_d    = 1'b1;
                pend_ch_d = mc_lvl ? CH_L : CH_R;
                dly_cnt_d = '0;
            end

            if (complete) begin
                if (!valid_q || word_ready) begin
                    word_l_d = sr_l_d;
                    word_r_d = sr_r_d;
                    valid_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end

            if (wd_cnt_d == WD_MAX) begin
                lost_d     = 1'b1;
                sr_l_d     = '0;
                sr_r_d     = '0;
                pair_cnt_d = '0;
                pend_d     = 1'b0;
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_sync_q <= '0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            word_l_q    <= '0;
            word_r_q    <= '0;
            pair_cnt_q  <= '0;
            dly_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            pend_ch_q   <= CH_L;
            pend_q      <= 1'b0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            data_sync_q <= data_sync_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            word_l_q    <= word_l_d;
            word_r_q    <= word_r_d;
            pair_cnt_q  <= pair_cnt_d;
            dly_cnt_q   <= dly_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            pend_ch_q   <= pend_ch_d;
            pend_q      <= pend_d;
            locked_q    <= locked_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            lost_q      <= lost_d;
        end
    end

    assign word_l     = word_l_q;
    assign word_r     = word_r_q;
    assign word_valid = valid_q;
    assign overrun    = ovr_q;
    assign clk_lost   = lost_q;

endmodule

// File: doc/pdm_pair_capture.md
Name: pdm_pair_capture

Overview:
- Receive end of the mic clocking path: takes the divided mic clock that drives the array, plus one shared stereo PDM data line from a mic pair.
- Samples the left mic on the rising mic-clock edge and the right mic on the falling edge, each after a programmable settling delay.
- Deserialises each channel into WORD_W-bit words, handed downstream with a valid/ready handshake.
- Flags overrun and loss of mic clock.

Parameters:
- WORD_W, 16, PDM bits per output word per channel (≥2).
- SAMPLE_DLY, 2, clk cycles from detected edge to data sample; must be < half mic-clock period in clk cycles.
- TIMEOUT, 32, clk cycles without any mic-clock edge before clk_lost asserts (≥4).

Ports:
- clk, in, 1, system clock; all logic rising-edge.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, capture enable; low = synchronous clear of capture state.
- mic_clk_in, in, 1, divided mic clock (50% duty), treated as asynchronous.
- mic_data_in, in, 1, shared PDM data line from the pair, asynchronous.
- word_l, out, WORD_W, left-channel word, first-received bit in MSB.
- word_r, out, WORD_W, right-channel word, same ordering.
- word_valid, out, 1, word_l/word_r hold a fresh pair.
- word_ready, in, 1, downstream accepts the pair when high with word_valid.
- overrun, out, 1, sticky: a completed pair was dropped.
- clk_lost, out, 1, no mic-clock edge for TIMEOUT cycles.

Behaviour:
- Reset (reset_n low, async): all registers 0; word_l=word_r=0, word_valid=0, overrun=0, clk_lost=0.
- Input sync: mic_clk_in and mic_data_in each pass through 2 flops. A third flop on the clock path gives edge detect. Edge flag at cycle E = 3 clk cycles after the pin transition. Rise = L, fall = R.
- Sampling:
  - Edge starts a delay counter that records the edge type.
  - At E+SAMPLE_DLY, the synchronised data bit is shifted into the L or R shift register (shift left, new bit at LSB).
  - If a new edge arrives while a sample is pending, the pending sample is taken that cycle and the counter restarts for the new edge.
- Alignment:
  - After enable rises, or after clk_lost clears, falling edges are ignored until the first rising edge.
  - Each pair therefore always starts with L.
- Pair counter (0..WORD_W-1):
  - Increments on each R sample.
  - On the R sample that completes WORD_W pairs, both shift registers load into word_l/word_r the next cycle, word_valid=1, and the counter wraps to 0.
- Handshake:
  - word_valid and the words stay stable until the cycle where word_valid & word_ready; word_valid drops the next cycle.
  - Completion in the same cycle as acceptance: the new pair loads and word_valid stays 1.
  - Completion while word_valid=1 and word_ready=0: the new pair is dropped, the held words are unchanged, overrun=1.
- overrun: sticky; cleared only by reset or enable low.
- Watchdog (only when enable=1):
  - Counter is cleared on every edge and saturates at TIMEOUT.
  - At TIMEOUT: clk_lost=1, partial shift data and pair counter cleared, realignment armed.
  - clk_lost clears on the next detected edge; that edge is only used for sampling if it is a rise.
- enable=0:
  - Clears shift registers, pair counter, delay counter, watchdog, word_valid, overrun and clk_lost next cycle.
  - word_l/word_r keep their last values.
- Reset mid-word: everything returns to reset values immediately; no partial word is ever emitted.

Decomposition:
- Package pdm_capture_pkg: default constants for WORD_W, SAMPLE_DLY, TIMEOUT; channel-select encoding (CH_L=0, CH_R=1).
- Sub-module edge_sync: 2-flop synchroniser plus edge-detect flop, outputs sync level, rise and fall pulses.
- Instantiate edge_sync for mic_clk_in; the data path uses a plain 2-flop sync.

Test Plan:
- Basic capture: mic_clk period 12 clk, L bits alternate 1,0,…, R bits all 1, ready=1 → after 16 mic periods word_l=16'hAAAA, word_r=16'hFFFF, word_valid high one cycle.
- Backpressure/overrun: ready=0 for two word periods, L=16'h1234 then 16'h5678 → word_l stays 16'h1234, overrun=1. Raise ready → valid drops next cycle. overrun stays 1 until enable low.
- Simultaneous accept and complete: ready pulses high in the exact cycle of the second pair's completion → word_l=second word, word_valid continuous, overrun=0.
- Clock loss: stop mic_clk after 5 pairs → clk_lost=1 exactly 32 cycles after the last edge flag; on restart, the first full word equals the new 16 pairs only, with no stale bits.
- Alignment: enable rises while mic_clk high → first falling edge ignored; the first word's MSB comes from the first rising edge.
- Reset mid-word: reset_n low after 7 pairs → all outputs 0 asynchronously; after release, the next word uses 16 fresh pairs.
